dest_scoreboard: RTL and testbench

- Consumer side of the RegDst destination selection. Takes the write-back destination address chosen at issue (Rt or Rd), marks that register pending until write-back retires it, and stalls any later instruction whose source registers are still pending.
- Sits between decode/issue and the pipeline hazard stall logic of the CPU datapath.
- Retirement is tracked by an internal fixed-latency delay line, so no separate write-back handshake is needed.

---
 rtl/dest_scoreboard_pkg.sv | 13 +
 rtl/sb_delay_line.sv | 38 +++
 rtl/dest_scoreboard.sv | 114 +++++++++++
 tb/tb_dest_scoreboard.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/dest_scoreboard_pkg.sv
// Shared constants and the delay-line entry type for the destination scoreboard.
package dest_scoreboard_pkg;

    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned REG_ZERO   = 0;
    localparam int unsigned PEND_W     = 3;

    typedef struct packed {
        logic                  valid;
        logic [ADDR_W_DEF-1:0] addr;
    } dl_entry_t;

endpackage

// File: rtl/sb_delay_line.sv
// Fixed-depth shift register of scoreboard entries; flush clears every stage.
module sb_delay_line
    import dest_scoreboard_pkg::*;
#(
    parameter int unsigned DEPTH   = 3,
    parameter type         entry_t = dl_entry_t
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   flush_i,
    input  entry_t in_i,
    output entry_t last_o
);

    entry_t stage_q [DEPTH];
    entry_t stage_d [DEPTH];

    always_comb begin
        stage_d = stage_q;
        if (flush_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) stage_d[i] = '0;
        end else begin
            stage_d[0] = in_i;
            for (int unsigned i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign last_o = stage_q[DEPTH-1];

endmodule

// File: rtl/dest_scoreboard.sv
// Destination scoreboard: tracks pending writers per register and stalls dependent issue.
// Define DEST_SCOREBOARD_WB_BYPASS_EN to let a source whose sole writer is retiring proceed.
module dest_scoreboard
    import dest_scoreboard_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned WB_LAT = 3,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              issue_valid_i,
    input  logic [ADDR_W-1:0] rs_i,
    input  logic              rs_used_i,
    input  logic [ADDR_W-1:0] rt_i,
    input  logic              rt_used_i,
    input  logic [ADDR_W-1:0] dst_i,
    input  logic              dst_we_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic              wb_valid_o,
    output logic [ADDR_W-1:0] wb_addr_o,
    output logic              busy_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam int unsigned NREG = 2 ** ADDR_W;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
    } entry_t;

    logic [PEND_W-1:0] pend_q [NREG];
    logic [PEND_W-1:0] pend_d [NREG];
    logic              wb_valid_q, wb_valid_d;
    logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    entry_t dl_in, dl_last;
    logic   rs_block, rt_block, accept, track;

    always_comb begin
        rs_block = (rs_i != ADDR_W'(REG_ZERO)) && (pend_q[rs_i] != '0);
        rt_block = (rt_i != ADDR_W'(REG_ZERO)) && (pend_q[rt_i] != '0);
`ifdef DEST_SCOREBOARD_WB_BYPASS_EN
        // The retiring writer is forwarded, so only a second in-flight writer blocks.
        if (dl_last.valid && dl_last.addr == rs_i && pend_q[rs_i] == PEND_W'(1)) rs_block = 1'b0;
        if (dl_last.valid && dl_last.addr == rt_i && pend_q[rt_i] == PEND_W'(1)) rt_block = 1'b0;
`endif
    end

    assign stall_o = issue_valid_i & ((rs_used_i & rs_block) | (rt_used_i & rt_block));
    assign accept  = issue_valid_i & ~stall_o & ~flush_i;
    assign track   = accept & dst_we_i & (dst_i != ADDR_W'(REG_ZERO));
    assign dl_in   = entry_t'{valid: track, addr: dst_i};

    sb_delay_line #(
        .DEPTH   (WB_LAT),
        .entry_t (entry_t)
    ) u_delay_line (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .in_i    (dl_in),
        .last_o  (dl_last)
    );

    always_comb begin
        for (int unsigned r = 0; r < NREG; r++) begin
            pend_d[r] = pend_q[r];
            if (flush_i) begin
                pend_d[r] = '0;
            end else begin
                if (track && dst_i == ADDR_W'(r)) pend_d[r] = pend_d[r] + PEND_W'(1);
                if (dl_last.valid && dl_last.addr == ADDR_W'(r)) pend_d[r] = pend_d[r] - PEND_W'(1);
            end
        end
    end

    always_comb begin
        busy_o = 1'b0;
        for (int unsigned r = 0; r < NREG; r++) begin
            if (pend_q[r] != '0) busy_o = 1'b1;
        end
    end

    always_comb begin
        wb_valid_d = dl_last.valid & ~flush_i;
        wb_addr_d  = wb_addr_q;
        if (wb_valid_d) wb_addr_d = dl_last.addr;
        stall_cnt_d = stall_cnt_q;
        if (stall_o && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int unsigned r = 0; r < NREG; r++) pend_q[r] <= '0;
            wb_valid_q  <= 1'b0;
            wb_addr_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            pend_q      <= pend_d;
            wb_valid_q  <= wb_valid_d;
            wb_addr_q   <= wb_addr_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign wb_valid_o  = wb_valid_q;
    assign wb_addr_o   = wb_addr_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_dest_scoreboard.sv
// Self-checking bench for dest_scoreboard: vector table, directed corner cases, random traffic.
module tb_dest_scoreboard;

    localparam int ADDR_W  = 5;
    localparam int WB_LAT  = 3;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef DEST_SCOREBOARD_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int C1 = BYP ? 2 : 3;

    logic              clk = 1'b0;
    logic              rst_i;
    logic              issue_valid_i, rs_used_i, rt_used_i, dst_we_i, flush_i;
    logic [ADDR_W-1:0] rs_i, rt_i, dst_i;
    logic              stall_o, wb_valid_o, busy_o;
    logic [ADDR_W-1:0] wb_addr_o;
    logic [CNT_W-1:0]  stall_cnt_o;

    always #5 clk = ~clk;

    dest_scoreboard #(
        .ADDR_W (ADDR_W),
        .WB_LAT (WB_LAT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .issue_valid_i (issue_valid_i),
        .rs_i          (rs_i),
        .rs_used_i     (rs_used_i),
        .rt_i          (rt_i),
        .rt_used_i     (rt_used_i),
        .dst_i         (dst_i),
        .dst_we_i      (dst_we_i),
        .flush_i       (flush_i),
        .stall_o       (stall_o),
        .wb_valid_o    (wb_valid_o),
        .wb_addr_o     (wb_addr_o),
        .busy_o        (busy_o),
        .stall_cnt_o   (stall_cnt_o)
    );

    typedef struct {
        logic iv; int rs; logic rsu; int rt; logic rtu; int dst; logic we; logic fl;
        logic e_st; logic e_bz; logic e_wv; int e_wa; int e_cnt;
    } vec_t;

    // In-flight writer: accepted at edge number n, pending while cyc < n+WB_LAT,
    // visible on wb_* while cyc == n+WB_LAT.
    typedef struct { int addr; int n; } infl_t;
    infl_t q[$];
    int    cyc = 0;
    int    m_cnt = 0;
    int    errors = 0;
    int    checks = 0;
    int    pulses = 0;
    vec_t  tab [12];

    function automatic vec_t mk(logic iv, int rs, logic rsu, int rt, logic rtu, int dst, logic we, logic fl);
        vec_t v;
        v.iv = iv; v.rs = rs; v.rsu = rsu; v.rt = rt; v.rtu = rtu;
        v.dst = dst; v.we = we; v.fl = fl;
        v.e_st = 0; v.e_bz = 0; v.e_wv = 0; v.e_wa = 0; v.e_cnt = 0;
        return v;
    endfunction

    function automatic vec_t ex(vec_t b, logic st, logic bz, logic wv, int wa, int cnt);
        vec_t v = b;
        v.e_st = st; v.e_bz = bz; v.e_wv = wv; v.e_wa = wa; v.e_cnt = cnt;
        return v;
    endfunction

    function automatic int m_pend(int r);
        int c = 0;
        foreach (q[i]) if (q[i].addr == r && cyc < q[i].n + WB_LAT) c++;
        return c;
    endfunction

    function automatic bit m_blocked(int r);
        int p;
        if (r == 0) return 0;
        p = m_pend(r);
        if (p == 0) return 0;
        if (BYP && p == 1)
            foreach (q[i]) if (q[i].addr == r && cyc == q[i].n + WB_LAT - 1) return 0;
        return 1;
    endfunction

    function automatic bit m_busy();
        foreach (q[i]) if (cyc < q[i].n + WB_LAT) return 1;
        return 0;
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input vec_t v, input bit tabchk);
        bit e_st, e_bz, e_wv;
        int e_wa;
        @(negedge clk);
        issue_valid_i = v.iv; rs_i = ADDR_W'(v.rs); rs_used_i = v.rsu;
        rt_i = ADDR_W'(v.rt); rt_used_i = v.rtu; dst_i = ADDR_W'(v.dst);
        dst_we_i = v.we; flush_i = v.fl;
        #1;
        e_st = v.iv && ((v.rsu && m_blocked(v.rs)) || (v.rtu && m_blocked(v.rt)));
        e_bz = m_busy();
        e_wv = 0; e_wa = 0;
        foreach (q[i]) if (cyc == q[i].n + WB_LAT) begin e_wv = 1; e_wa = q[i].addr; end
        check("stall_o", int'(stall_o), int'(e_st));
        check("busy_o", int'(busy_o), int'(e_bz));
        check("wb_valid_o", int'(wb_valid_o), int'(e_wv));
        if (e_wv) check("wb_addr_o", int'(wb_addr_o), e_wa);
        check("stall_cnt_o", int'(stall_cnt_o), m_cnt);
        if (wb_valid_o === 1'b1) pulses++;
        if (tabchk) begin
            check("tab_stall", int'(stall_o), int'(v.e_st));
            check("tab_busy", int'(busy_o), int'(v.e_bz));
            check("tab_wb_valid", int'(wb_valid_o), int'(v.e_wv));
            if (v.e_wv) check("tab_wb_addr", int'(wb_addr_o), v.e_wa);
            check("tab_stall_cnt", int'(stall_cnt_o), v.e_cnt);
        end
        @(posedge clk);
        if (e_st && m_cnt < CNT_MAX) m_cnt++;
        if (v.fl) q.delete();
        cyc++;
        if (v.iv && !e_st && !v.fl && v.we && v.dst != 0) q.push_back('{addr: v.dst, n: cyc});
        for (int i = q.size() - 1; i >= 0; i--) if (q[i].n + WB_LAT < cyc) q.delete(i);
    endtask

    task automatic drive_idle();
        issue_valid_i = 0; rs_i = '0; rs_used_i = 0; rt_i = '0; rt_used_i = 0;
        dst_i = '0; dst_we_i = 0; flush_i = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_i = 0;
        drive_idle();
        q.delete();
        m_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall", int'(stall_o), 0);
        check("rst_busy", int'(busy_o), 0);
        check("rst_wb_valid", int'(wb_valid_o), 0);
        check("rst_wb_addr", int'(wb_addr_o), 0);
        check("rst_stall_cnt", int'(stall_cnt_o), 0);
        @(negedge clk);
        rst_i = 1;
    endtask

    initial begin
        vec_t idle, w5, rd5, w3, rd3;
        rst_i = 0;
        drive_idle();
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0);
        w5   = mk(1, 0, 0, 0, 0, 5, 1, 0);
        rd5  = mk(1, 5, 1, 0, 0, 0, 0, 0);
        w3   = mk(1, 0, 0, 0, 0, 3, 1, 0);
        rd3  = mk(1, 3, 1, 0, 0, 0, 0, 0);

        tab[0]  = ex(w5,  0, 0, 0, 0, 0);
        tab[1]  = ex(rd5, 1, 1, 0, 0, 0);
        tab[2]  = ex(rd5, 1, 1, 0, 0, 1);
        tab[3]  = ex(rd5, !BYP, 1, 0, 0, 2);
        tab[4]  = ex(rd5, 0, 0, 1, 5, C1);
        tab[5]  = ex(idle, 0, 0, 0, 0, C1);
        tab[6]  = ex(mk(1, 0, 0, 0, 0, 0, 1, 0), 0, 0, 0, 0, C1);
        tab[7]  = ex(mk(1, 0, 1, 0, 1, 0, 0, 0), 0, 0, 0, 0, C1);
        for (int i = 8; i < 12; i++) tab[i] = ex(idle, 0, 0, 0, 0, C1);

        do_reset();
        for (int i = 0; i < 12; i++) step(tab[i], 1'b1);

        // WAW on r7: reader waits for the second retirement; two pulses expected.
        pulses = 0;
        step(mk(1, 0, 0, 0, 0, 7, 1, 0), 0);
        step(mk(1, 0, 0, 0, 0, 7, 1, 0), 0);
        for (int i = 0; i < 4; i++) step(mk(1, 0, 0, 7, 1, 0, 0, 0), 0);
        for (int i = 0; i < 4; i++) step(idle, 0);
        check("waw_pulses", pulses, 2);

        // Flush one cycle after issuing r9; the flush-cycle issue of r11 is dropped.
        step(mk(1, 0, 0, 0, 0, 9, 1, 0), 0);
        step(mk(1, 0, 0, 0, 0, 11, 1, 1), 0);
        pulses = 0;
        step(mk(1, 9, 1, 11, 1, 0, 0, 0), 0);
        check("flush_busy", int'(busy_o), 0);
        check("flush_reader_stall", int'(stall_o), 0);
        for (int i = 0; i < 5; i++) step(idle, 0);
        check("flush_pulses", pulses, 0);

        // Alternating writer/reader on r3 keeps stalling until the counter saturates.
        for (int i = 0; i < 40; i++) step((i % 2 == 0) ? w3 : rd3, 0);
        step(w3, 0);
        @(negedge clk);
        issue_valid_i = 1; rs_i = 5'd3; rs_used_i = 1; dst_we_i = 0; dst_i = '0;
        #1;
        check("sat_stall", int'(stall_o), 1);
        check("sat_cnt", int'(stall_cnt_o), CNT_MAX);
        #1 rst_i = 0;
        #1;
        check("async_rst_stall", int'(stall_o), 0);
        check("async_rst_busy", int'(busy_o), 0);
        check("async_rst_wb_valid", int'(wb_valid_o), 0);
        check("async_rst_wb_addr", int'(wb_addr_o), 0);
        check("async_rst_cnt", int'(stall_cnt_o), 0);
        q.delete();
        m_cnt = 0;
        @(negedge clk);
        drive_idle();
        rst_i = 1;

        for (int i = 0; i < 400; i++) begin
            vec_t v;
            v = mk(($urandom_range(0, 3) != 0), $urandom_range(0, 7), $urandom_range(0, 1),
                   $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
                   $urandom_range(0, 1), ($urandom_range(0, 24) == 0));
            step(v, 0);
        end
        for (int i = 0; i < 5; i++) step(idle, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
